window_spill_ctrl: RTL and testbench
====================================

WINDOW_SPILL_CTRL -- requirements
Module: window_spill_ctrl

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on posedge.
REQ-002 The block SHALL have the port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have the ports save_req and restore_req, input, 1 bit each: window-shift requests, sampled only in IDLE.
REQ-004 The block SHALL have the port cwp, output, 2 bits: current window pointer, drives the register file window select.
REQ-005 The block SHALL have the ports busy and done, output, 1 bit each: busy = FSM not IDLE; done = 1-cycle pulse, registered, high in the cycle cwp shows its new value.
REQ-006 The block SHALL have the ports rf_rd_win[1:0], rf_rd_idx[1:0] (out) and rf_rd_data[15:0] (in): combinational register-file read port, data valid in the same cycle.
REQ-007 The block SHALL have the ports rf_wr_en, rf_wr_win[1:0], rf_wr_idx[1:0] and rf_wr_data[15:0], all output: register-file write port, held for one full cycle.
REQ-008 The block SHALL have the ports mem_addr[7:0], mem_wr_en, mem_wr_data[15:0], mem_rd_en (out) and mem_rd_data[15:0] (in): spill-stack RAM with synchronous read and 1-cycle latency.
REQ-009 The block SHALL have the port err, output, 2 bits: 1-cycle pulse; bit0 = stack overflow, bit1 = window underflow.

Function
REQ-010 The block SHALL implement window w as mapping indices 0..3 to physical registers 2w..2w+3 mod 8; at most 3 windows SHALL be resident at once (wcnt, 1..3).
REQ-011 The FSM SHALL have the states IDLE, SPILL0, SPILL1, FILL0, FILL1 and FILL2.
REQ-012 When save_req and restore_req are both high in IDLE, save SHALL win; requests outside IDLE SHALL be ignored.
REQ-013 For a save with wcnt<3, the block SHALL set cwp=cwp+1 and wcnt+1, with done at t+1 and no FSM transition.
REQ-014 For a save with wcnt==3 and sp!=254, the block SHALL spill the oldest window o=cwp-2:
  - SPILL0: read o idx0 and write it to mem[sp].
  - SPILL1: read o idx1 and write it to mem[sp+1].
  - Next cycle: cwp+1, sp+2, wcnt unchanged, done.
REQ-015 For a save with wcnt==3 and sp==254, the block SHALL pulse err[0] at t+1 and leave cwp, sp and wcnt unchanged.
REQ-016 For a restore with wcnt>1, the block SHALL set cwp=cwp-1 and wcnt-1, with done at t+1.
REQ-017 For a restore with wcnt==1 and sp>0, the block SHALL fill window f=cwp-1:
  - FILL0: read mem[sp-1].
  - FILL1: read mem[sp-2], and write the first read data to f idx1.
  - FILL2: write the second read data to f idx0.
  - Next cycle: cwp-1, sp-2, done.
REQ-018 For a restore with wcnt==1 and sp==0, the block SHALL pulse err[1] and make no state change.
REQ-019 The block SHALL update cwp, sp and wcnt only on completion, and SHALL apply modulo-4 arithmetic to cwp.
REQ-020 When not in the corresponding states, the block SHALL hold rf_wr_en, mem_wr_en and mem_rd_en at 0.

Reset
REQ-021 Reset SHALL force cwp=0, wcnt=1, sp=0, state IDLE, and all outputs to 0.
REQ-022 Reset mid-spill or mid-fill SHALL abort the operation; partial RAM writes SHALL be don't-care because sp is unchanged.

Configuration
REQ-023 When WSC_STICKY_ERR_EN is defined, the block SHALL add the output err_sticky[1:0] and the input err_clr; err_sticky SHALL OR-accumulate err and clear on err_clr or rst, with set winning over a simultaneous clear.
REQ-024 When WSC_STICKY_ERR_EN is undefined, the ports of REQ-023 SHALL be absent and the behaviour SHALL otherwise be identical.

Structure
REQ-025 The shared package wsc_pkg SHALL hold NUM_WIN=4, REGS_PER_WIN=4, WIN_OVERLAP=2, SP_W=8, SP_MAX=254, the FSM state enum and the err bit positions.
REQ-026 The block SHALL be a single module with no sub-module.

Verification
REQ-027 After reset, 2 saves SHALL give cwp 0→1→2, wcnt=3, and done each at t+1 with no memory access.
REQ-028 A third save (phys R0=10, R1=20) SHALL give mem[0]=10, mem[1]=20, sp=2, cwp=3, and done at t+3.
REQ-029 Starting from REQ-028's end state, 2 restores SHALL give cwp 3→2→1 with wcnt=1; a third restore SHALL fill window 0 with idx1=20, idx0=10, sp=0, cwp=0, and done at t+4.
REQ-030 A restore at reset state SHALL pulse err=2'b10, with cwp=0 and sp=0 unchanged.
REQ-031 Simultaneous save_req and restore_req in IDLE SHALL perform the save; rst asserted in SPILL1 SHALL give cwp=0, sp=0, and busy=0 next cycle.
REQ-032 With sp forced to 254, wcnt=3 and a save request, the block SHALL pulse err=2'b01 with no mem_wr_en; with WSC_STICKY_ERR_EN, err_sticky=01 until err_clr.

Source files
------------

// File: rtl/wsc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wsc_pkg
// Brief    : Shared constants, FSM state encoding and window helpers for
//            window_spill_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
package wsc_pkg;

    localparam int NUM_WIN      = 4;
    localparam int REGS_PER_WIN = 4;
    localparam int WIN_OVERLAP  = 2;
    localparam int SP_W         = 8;
    localparam logic [SP_W-1:0] SP_MAX = 8'd254;

    localparam int ERR_OVF = 0;
    localparam int ERR_UNF = 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SPILL0 = 3'd1,
        SPILL1 = 3'd2,
        FILL0  = 3'd3,
        FILL1  = 3'd4,
        FILL2  = 3'd5
    } wsc_state_e;

    // Window pointers wrap modulo NUM_WIN, which the 2-bit width gives for free.
    function automatic logic [1:0] win_back(input logic [1:0] w, input logic [1:0] k);
        return w - k;
    endfunction

endpackage
`default_nettype wire

// File: rtl/window_spill_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : window_spill_ctrl
// Brief    : Register-window save/restore controller that spills the oldest
//            window to a RAM stack and fills it back on underflow.
// Options  : WSC_STICKY_ERR_EN adds err_clr input and err_sticky output.
// Revision : 1.0 - initial release
// ============================================================================
module window_spill_ctrl
    import wsc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
`ifdef WSC_STICKY_ERR_EN
    input  logic        err_clr,
    output logic [1:0]  err_sticky,
`endif
    input  logic        save_req,
    input  logic        restore_req,
    output logic [1:0]  cwp,
    output logic        busy,
    output logic        done,
    output logic [1:0]  rf_rd_win,
    output logic [1:0]  rf_rd_idx,
    input  logic [15:0] rf_rd_data,
    output logic        rf_wr_en,
    output logic [1:0]  rf_wr_win,
    output logic [1:0]  rf_wr_idx,
    output logic [15:0] rf_wr_data,
    output logic [7:0]  mem_addr,
    output logic        mem_wr_en,
    output logic [15:0] mem_wr_data,
    output logic        mem_rd_en,
    input  logic [15:0] mem_rd_data,
    output logic [1:0]  err
);

    wsc_state_e      state_q;
    logic [1:0]      cwp_q;
    logic [1:0]      wcnt_q;
    logic [SP_W-1:0] sp_q;
    logic            done_q;
    logic [1:0]      err_q;
    logic [1:0]      err_d;

    always_comb begin
        err_d = 2'b00;
        if (state_q == IDLE) begin
            if (save_req) begin
                err_d[ERR_OVF] = (wcnt_q == 2'd3) && (sp_q == SP_MAX);
            end else if (restore_req) begin
                err_d[ERR_UNF] = (wcnt_q == 2'd1) && (sp_q == '0);
            end
        end
    end

    // Architectural state moves only when an operation completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cwp_q   <= 2'd0;
            wcnt_q  <= 2'd1;
            sp_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 2'b00;
        end else begin
            done_q <= 1'b0;
            err_q  <= err_d;
            case (state_q)
                IDLE: begin
                    if (save_req) begin
                        if (wcnt_q != 2'd3) begin
                            cwp_q  <= cwp_q + 2'd1;
                            wcnt_q <= wcnt_q + 2'd1;
                            done_q <= 1'b1;
                        end else if (sp_q != SP_MAX) begin
                            state_q <= SPILL0;
                        end
                    end else if (restore_req) begin
                        if (wcnt_q != 2'd1) begin
                            cwp_q  <= cwp_q - 2'd1;
                            wcnt_q <= wcnt_q - 2'd1;
                            done_q <= 1'b1;
                        end else if (sp_q != '0) begin
                            state_q <= FILL0;
                        end
                    end
                end
                SPILL0: state_q <= SPILL1;
                SPILL1: begin
                    state_q <= IDLE;
                    cwp_q   <= cwp_q + 2'd1;
                    sp_q    <= sp_q + SP_W'(2);
                    done_q  <= 1'b1;
                end
                FILL0: state_q <= FILL1;
                FILL1: state_q <= FILL2;
                FILL2: begin
                    state_q <= IDLE;
                    cwp_q   <= cwp_q - 2'd1;
                    sp_q    <= sp_q - SP_W'(2);
                    done_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Fill data arrives from the RAM one cycle after its address, so the
    // write into the window trails the read by one state.
    always_comb begin
        rf_rd_win   = 2'd0;
        rf_rd_idx   = 2'd0;
        rf_wr_en    = 1'b0;
        rf_wr_win   = 2'd0;
        rf_wr_idx   = 2'd0;
        rf_wr_data  = 16'd0;
        mem_addr    = 8'd0;
        mem_wr_en   = 1'b0;
        mem_wr_data = 16'd0;
        mem_rd_en   = 1'b0;
        case (state_q)
            SPILL0: begin
                rf_rd_win   = win_back(cwp_q, 2'd2);
                rf_rd_idx   = 2'd0;
                mem_addr    = sp_q;
                mem_wr_en   = 1'b1;
                mem_wr_data = rf_rd_data;
            end
            SPILL1: begin
                rf_rd_win   = win_back(cwp_q, 2'd2);
                rf_rd_idx   = 2'd1;
                mem_addr    = sp_q + SP_W'(1);
                mem_wr_en   = 1'b1;
                mem_wr_data = rf_rd_data;
            end
            FILL0: begin
                mem_addr  = sp_q - SP_W'(1);
                mem_rd_en = 1'b1;
            end
            FILL1: begin
                mem_addr   = sp_q - SP_W'(2);
                mem_rd_en  = 1'b1;
                rf_wr_en   = 1'b1;
                rf_wr_win  = win_back(cwp_q, 2'd1);
                rf_wr_idx  = 2'd1;
                rf_wr_data = mem_rd_data;
            end
            FILL2: begin
                rf_wr_en   = 1'b1;
                rf_wr_win  = win_back(cwp_q, 2'd1);
                rf_wr_idx  = 2'd0;
                rf_wr_data = mem_rd_data;
            end
            default: ;
        endcase
    end

`ifdef WSC_STICKY_ERR_EN
    logic [1:0] err_sticky_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_sticky_q <= 2'b00;
        end else begin
            err_sticky_q <= (err_sticky_q & ~{2{err_clr}}) | err_d;
        end
    end

    assign err_sticky = err_sticky_q;
`endif

    assign cwp  = cwp_q;
    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_window_spill_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_window_spill_ctrl
// Brief    : Self-checking bench for window_spill_ctrl with register-file and
//            spill-RAM environment models and a transaction-level reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_window_spill_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        save_req, restore_req;
    logic [1:0]  cwp;
    logic        busy, done;
    logic [1:0]  rf_rd_win, rf_rd_idx;
    logic [15:0] rf_rd_data;
    logic        rf_wr_en;
    logic [1:0]  rf_wr_win, rf_wr_idx;
    logic [15:0] rf_wr_data;
    logic [7:0]  mem_addr;
    logic        mem_wr_en;
    logic [15:0] mem_wr_data;
    logic        mem_rd_en;
    logic [15:0] mem_rd_data;
    logic [1:0]  err;
`ifdef WSC_STICKY_ERR_EN
    logic        err_clr;
    logic [1:0]  err_sticky;
`endif

    always #5 clk = ~clk;

    window_spill_ctrl dut (
        .clk         (clk),
        .rst         (rst),
`ifdef WSC_STICKY_ERR_EN
        .err_clr     (err_clr),
        .err_sticky  (err_sticky),
`endif
        .save_req    (save_req),
        .restore_req (restore_req),
        .cwp         (cwp),
        .busy        (busy),
        .done        (done),
        .rf_rd_win   (rf_rd_win),
        .rf_rd_idx   (rf_rd_idx),
        .rf_rd_data  (rf_rd_data),
        .rf_wr_en    (rf_wr_en),
        .rf_wr_win   (rf_wr_win),
        .rf_wr_idx   (rf_wr_idx),
        .rf_wr_data  (rf_wr_data),
        .mem_addr    (mem_addr),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_data (mem_wr_data),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_data (mem_rd_data),
        .err         (err)
    );

    // Environment: 8-entry physical register file and 256-entry sync-read RAM.
    logic [15:0] rf  [8];
    logic [15:0] ram [256];
    logic        tbw_en;
    logic [2:0]  tbw_idx;
    logic [15:0] tbw_val;
    int          wr_cnt, rd_cnt;

    function automatic logic [2:0] phys(input logic [1:0] w, input logic [1:0] i);
        return {w, 1'b0} + {1'b0, i};
    endfunction

    assign rf_rd_data = rf[phys(rf_rd_win, rf_rd_idx)];

    always @(posedge clk) begin
        if (rf_wr_en) rf[phys(rf_wr_win, rf_wr_idx)] <= rf_wr_data;
        else if (tbw_en) rf[tbw_idx] <= tbw_val;
        if (mem_wr_en) begin
            ram[mem_addr] <= mem_wr_data;
            wr_cnt <= wr_cnt + 1;
        end
        if (mem_rd_en) begin
            mem_rd_data <= ram[mem_addr];
            rd_cnt <= rd_cnt + 1;
        end
    end

    // Reference model state
    int          m_cwp, m_wcnt, m_sp;
    logic [15:0] exp_rf  [8];
    logic [15:0] exp_mem [256];
    int          n_vec, n_bad;

    typedef struct {
        bit         save;
        bit         rest;
        bit         clob;
        logic [1:0] cwp;
        int         lat;
        logic [1:0] err;
    } vec_t;
    vec_t tab [8];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cwp  = 0;
        m_wcnt = 1;
        m_sp   = 0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic rf_poke(input int idx, input logic [15:0] val);
        @(negedge clk);
        tbw_en  = 1'b1;
        tbw_idx = 3'(idx);
        tbw_val = val;
        @(posedge clk);
        #1;
        tbw_en = 1'b0;
        exp_rf[idx] = val;
    endtask

    task automatic do_op(input bit s, input bit r, input bit use_tab, input logic [1:0] t_cwp,
                         input int t_lat, input logic [1:0] t_err, input string tag);
        int          e_lat, lat, wc0, rc0, e_wr, e_rd, o, f, sp0;
        logic [1:0]  e_err, g_err, e_cwp;
        logic        g_done, found, spilled;
        logic [127:0] g_rf, e_rfp;
        e_err = 2'b00; e_lat = 1; e_wr = 0; e_rd = 0; spilled = 1'b0; sp0 = m_sp;
        if (s) begin
            if (m_wcnt < 3) begin
                m_cwp = (m_cwp + 1) % 4;
                m_wcnt++;
            end else if (m_sp == 254) begin
                e_err = 2'b01;
            end else begin
                o = (m_cwp + 2) % 4;
                exp_mem[m_sp]     = exp_rf[(2 * o) % 8];
                exp_mem[m_sp + 1] = exp_rf[(2 * o + 1) % 8];
                m_sp += 2;
                m_cwp = (m_cwp + 1) % 4;
                e_lat = 3; e_wr = 2; spilled = 1'b1;
            end
        end else if (r) begin
            if (m_wcnt > 1) begin
                m_cwp = (m_cwp + 3) % 4;
                m_wcnt--;
            end else if (m_sp == 0) begin
                e_err = 2'b10;
            end else begin
                f = (m_cwp + 3) % 4;
                exp_rf[(2 * f + 1) % 8] = exp_mem[m_sp - 1];
                exp_rf[(2 * f) % 8]     = exp_mem[m_sp - 2];
                m_sp -= 2;
                m_cwp = f;
                e_lat = 4; e_rd = 2;
            end
        end
        e_cwp = 2'(m_cwp);
        if (use_tab) begin
            e_cwp = t_cwp;
            e_lat = t_lat;
            e_err = t_err;
        end

        @(negedge clk);
        wc0 = wr_cnt;
        rc0 = rd_cnt;
        save_req    = s;
        restore_req = r;
        @(posedge clk);
        #1;
        save_req    = 1'b0;
        restore_req = 1'b0;
        found = 1'b0; lat = 0; g_done = 1'b0; g_err = 2'b00;
        for (int k = 1; k <= 8 && !found; k++) begin
            if (done || err != 2'b00) begin
                found = 1'b1; lat = k; g_done = done; g_err = err;
            end else begin
                @(posedge clk);
                #1;
            end
        end

        check({tag, " latency"}, 128'(lat), 128'(e_lat));
        check({tag, " done/err"}, {125'd0, g_done, g_err}, {125'd0, (e_err == 2'b00), e_err});
        check({tag, " cwp"}, 128'(cwp), 128'(e_cwp));
        check({tag, " busy at end"}, 128'(busy), 128'd0);
        check({tag, " mem writes"}, 128'(wr_cnt - wc0), 128'(e_wr));
        check({tag, " mem reads"}, 128'(rd_cnt - rc0), 128'(e_rd));
        for (int i = 0; i < 8; i++) begin
            g_rf[i*16 +: 16]  = rf[i];
            e_rfp[i*16 +: 16] = exp_rf[i];
        end
        check({tag, " regfile"}, g_rf, e_rfp);
        if (spilled) begin
            check({tag, " spill mem"}, {96'd0, ram[sp0], ram[sp0 + 1]},
                  {96'd0, exp_mem[sp0], exp_mem[sp0 + 1]});
        end
        @(posedge clk);
        #1;
        check({tag, " pulse end"}, {124'd0, done, err, busy}, 128'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pick;
        tab[0] = '{1'b1, 1'b0, 1'b0, 2'd1, 1, 2'b00};
        tab[1] = '{1'b1, 1'b0, 1'b0, 2'd2, 1, 2'b00};
        tab[2] = '{1'b1, 1'b0, 1'b0, 2'd3, 3, 2'b00};
        tab[3] = '{1'b0, 1'b1, 1'b0, 2'd2, 1, 2'b00};
        tab[4] = '{1'b0, 1'b1, 1'b0, 2'd1, 1, 2'b00};
        tab[5] = '{1'b0, 1'b1, 1'b1, 2'd0, 4, 2'b00};
        tab[6] = '{1'b0, 1'b1, 1'b0, 2'd0, 1, 2'b10};
        tab[7] = '{1'b1, 1'b1, 1'b0, 2'd1, 1, 2'b00};

        n_vec = 0; n_bad = 0;
        rst = 1'b1; save_req = 1'b0; restore_req = 1'b0;
        tbw_en = 1'b0; tbw_idx = 3'd0; tbw_val = 16'd0;
`ifdef WSC_STICKY_ERR_EN
        err_clr = 1'b0;
`endif
        for (int i = 0; i < 8; i++) rf_poke(i, 16'(100 + i));
        rf_poke(0, 16'd10);
        rf_poke(1, 16'd20);

        apply_reset();
        #1;
        check("reset outputs", {121'd0, cwp, busy, done, err, rf_wr_en, mem_wr_en, mem_rd_en} >> 0,
              128'd0);

        // Directed sequence: quick saves, spill, quick restores, fill, underflow, priority.
        for (int i = 0; i < 8; i++) begin
            if (tab[i].clob) begin
                rf_poke(0, 16'hDEAD);
                rf_poke(1, 16'hBEEF);
            end
            do_op(tab[i].save, tab[i].rest, 1'b1, tab[i].cwp, tab[i].lat, tab[i].err,
                  $sformatf("tab%0d", i));
        end

        // Randomized save/restore traffic with occasional register updates.
        apply_reset();
        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 7) == 0) rf_poke($urandom_range(0, 7), 16'($urandom));
            pick = $urandom_range(0, 99);
            if (pick < 48)      do_op(1'b1, 1'b0, 1'b0, 2'd0, 0, 2'b00, $sformatf("rnd%0d save", n));
            else if (pick < 94) do_op(1'b0, 1'b1, 1'b0, 2'd0, 0, 2'b00, $sformatf("rnd%0d rest", n));
            else                do_op(1'b1, 1'b1, 1'b0, 2'd0, 0, 2'b00, $sformatf("rnd%0d both", n));
        end

        // Drive the stack to its limit, then one more save must overflow.
        apply_reset();
        for (int n = 0; n < 129; n++) do_op(1'b1, 1'b0, 1'b0, 2'd0, 0, 2'b00, $sformatf("fill%0d", n));
        do_op(1'b1, 1'b0, 1'b1, 2'(m_cwp), 1, 2'b01, "overflow");
`ifdef WSC_STICKY_ERR_EN
        check("sticky set", 128'(err_sticky), 128'd1);
        repeat (3) @(posedge clk);
        #1;
        check("sticky hold", 128'(err_sticky), 128'd1);
        @(negedge clk);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        check("sticky clear", 128'(err_sticky), 128'd0);
`endif

        // Reset while in SPILL1 aborts the spill without moving sp.
        apply_reset();
        do_op(1'b1, 1'b0, 1'b0, 2'd0, 0, 2'b00, "pre save1");
        do_op(1'b1, 1'b0, 1'b0, 2'd0, 0, 2'b00, "pre save2");
        @(negedge clk);
        save_req = 1'b1;
        @(posedge clk);
        #1;
        save_req = 1'b0;
        check("spill busy", 128'(busy), 128'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort state", {124'd0, cwp, busy, done}, 128'd0);
        model_reset();
        do_op(1'b0, 1'b1, 1'b1, 2'd0, 1, 2'b10, "abort underflow");
        do_op(1'b1, 1'b0, 1'b1, 2'd1, 1, 2'b00, "abort save");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
